// File: rtl/pixel_line_mirror.sv
// Streaming horizontal mirror: each raster row is captured into one of two
// ping-pong line banks and drained in reverse column order from the other.
module pixel_line_mirror #(
    parameter int COLS   = 512,
    parameter int ROWS   = 512,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_frame_end
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW = $clog2(2 * COLS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [DATA_W-1:0] line_mem [2*COLS];

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic              rd_bank_q, rd_bank_d;
    logic [CW-1:0]     rd_col_q, rd_col_d;
    logic [RW-1:0]     rd_row_q, rd_row_d;
    logic [DATA_W-1:0] out_data_q;

    logic          accept, transfer, wr_done, rd_done;
    logic [AW-1:0] wr_addr, rd_addr;

    always_comb begin
        in_ready      = !full_q[wr_bank_q];
        out_valid     = full_q[rd_bank_q];
        accept        = in_valid && in_ready;
        transfer      = out_valid && out_ready;
        wr_done       = accept && (wr_col_q == COL_LAST);
        rd_done       = transfer && (rd_col_q == COL_LAST);
        out_last      = out_valid && (rd_col_q == COL_LAST);
        out_frame_end = out_last && (rd_row_q == ROW_LAST);
        out_data      = out_data_q;

        wr_col_d  = wr_col_q;
        wr_bank_d = wr_bank_q;
        if (accept) begin
            wr_col_d = wr_done ? '0 : wr_col_q + CW'(1);
            if (wr_done) begin
                wr_bank_d = !wr_bank_q;
            end
        end

        rd_col_d  = rd_col_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        if (transfer) begin
            rd_col_d = rd_done ? '0 : rd_col_q + CW'(1);
            if (rd_done) begin
                rd_bank_d = !rd_bank_q;
                rd_row_d  = (rd_row_q == ROW_LAST) ? '0 : rd_row_q + RW'(1);
            end
        end

        wr_addr = AW'(wr_bank_q ? COLS : 0) + AW'(wr_col_q);
        // Read address is looked up one cycle ahead so the RAM read can be registered.
        rd_addr = AW'(rd_bank_d ? COLS : 0) + AW'(COL_LAST - rd_col_d);
    end

    // A bank is only written while empty and only drained while full,
    // so fill and drain of the same bank never coincide.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic bank_fill, bank_drain;
        assign bank_fill  = wr_done && (wr_bank_q == 1'(gi));
        assign bank_drain = rd_done && (rd_bank_q == 1'(gi));
        assign full_d[gi] = bank_fill || (full_q[gi] && !bank_drain);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_col_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
            rd_row_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_col_q  <= wr_col_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
            rd_row_q  <= rd_row_d;
        end
    end

    // The final write of a row lands on the address the idle reader is
    // pointing at, so that pixel is forwarded straight into the output register.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            line_mem[wr_addr] <= in_data;
        end
        if (accept && !rst && (wr_addr == rd_addr)) begin
            out_data_q <= in_data;
        end else begin
            out_data_q <= line_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_pixel_line_mirror.sv
// Scoreboard bench for pixel_line_mirror: a row-reversal model feeds expected
// pixels into queues that independent monitors drain as the DUTs emit output.
module tb_pixel_line_mirror;

    localparam int A_COLS = 4;
    localparam int A_ROWS = 2;
    localparam int B_COLS = 2;
    localparam int B_ROWS = 1;
    localparam int DW     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_last, out_frame_end;
    logic [DW-1:0] in_data, out_data;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_out_frame_end;
    logic [DW-1:0] b_in_data, b_out_data;

    pixel_line_mirror #(.COLS(A_COLS), .ROWS(A_ROWS), .DATA_W(DW)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_frame_end(out_frame_end)
    );

    pixel_line_mirror #(.COLS(B_COLS), .ROWS(B_ROWS), .DATA_W(DW)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_frame_end(b_out_frame_end)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          f;
    } exp_t;

    int checks = 0;
    int errors = 0;

    exp_t          a_q[$];
    exp_t          b_q[$];
    logic [DW-1:0] a_row[A_COLS];
    logic [DW-1:0] b_row[B_COLS];
    int a_wc = 0, a_rr = 0, b_wc = 0, b_rr = 0;
    int a_outs = 0, a_fends = 0, b_outs = 0, b_fends = 0;

    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_l, hold_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: collect accepted pixels per row; a complete row is
    // queued reversed, with row-end and frame-end flags on its last entry.
    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
            a_wc = 0;
            a_rr = 0;
        end else if (in_valid && in_ready) begin
            a_row[a_wc] = in_data;
            a_wc++;
            if (a_wc == A_COLS) begin
                for (int c = 0; c < A_COLS; c++)
                    a_q.push_back('{a_row[A_COLS-1-c], c == A_COLS-1,
                                    (c == A_COLS-1) && (a_rr == A_ROWS-1)});
                a_wc = 0;
                a_rr = (a_rr + 1) % A_ROWS;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_q.delete();
            b_wc = 0;
            b_rr = 0;
        end else if (b_in_valid && b_in_ready) begin
            b_row[b_wc] = b_in_data;
            b_wc++;
            if (b_wc == B_COLS) begin
                for (int c = 0; c < B_COLS; c++)
                    b_q.push_back('{b_row[B_COLS-1-c], c == B_COLS-1,
                                    (c == B_COLS-1) && (b_rr == B_ROWS-1)});
                b_wc = 0;
                b_rr = (b_rr + 1) % B_ROWS;
            end
        end
    end

    // Monitors: compare each transferred pixel against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk("a_hold", {out_valid, out_last, out_frame_end, out_data},
                    {1'b1, hold_l, hold_f, hold_d});
            hold_pend = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            hold_f = out_frame_end;
            if (out_valid && out_ready) begin
                if (a_q.size() == 0) begin
                    chk("a_spurious_out", out_data, 32'hFFFF_FFFF);
                end else begin
                    e = a_q.pop_front();
                    chk("a_data", out_data, e.d);
                    chk("a_last", out_last, e.l);
                    chk("a_frame_end", out_frame_end, e.f);
                    a_outs++;
                    if (out_frame_end) a_fends++;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                chk("b_spurious_out", b_out_data, 32'hFFFF_FFFF);
            end else begin
                e = b_q.pop_front();
                chk("b_data", b_out_data, e.d);
                chk("b_last", b_out_last, e.l);
                chk("b_frame_end", b_out_frame_end, e.f);
                b_outs++;
                if (b_out_frame_end) b_fends++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input logic [DW-1:0] d);
        logic ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
        end
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (a_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("a_drain_left", a_q.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted, next_px, sent, cyc, fe0, o0, n;
        logic found;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_end", out_frame_end, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);

        // Basic frame with free-flowing sink, plus first-pixel latency.
        out_ready = 1'b1;
        for (int p = 1; p <= 3; p++) push_px(DW'(p));
        chk("lat_before_last_col", out_valid, 0);
        push_px(DW'(4));
        chk("lat_after_last_col", out_valid, 1);
        chk("lat_first_data", out_data, 4);
        for (int p = 5; p <= 8; p++) push_px(DW'(p));
        drain_a();

        // Sink stalled: exactly two rows fit, then the writer blocks.
        do_reset();
        out_ready = 1'b0;
        accepted = 0;
        next_px = 1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data = DW'(next_px);
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                if (next_px < 12) next_px++;
            end
            tick();
        end
        chk("stall_accepted", accepted, 8);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 4);

        // Release the sink: bank 0 frees after pixel 1 is read.
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
                found = 1'b1;
                break;
            end
        end
        chk("release_found_last", found, 1);
        chk("release_last_data", out_data, 1);
        chk("release_ready_before", in_ready, 0);
        tick();
        chk("release_ready_after", in_ready, 1);
        for (int p = 9; p <= 12; p++) push_px(DW'(p));
        drain_a();

        // Reset with row 0 partly drained and row 1 partly captured.
        do_reset();
        out_ready = 1'b0;
        for (int p = 1; p <= 6; p++) push_px(DW'(p));
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_last", out_last, 0);
        out_ready = 1'b1;
        for (int p = 1; p <= 8; p++) push_px(DW'(p));
        drain_a();

        // Random valid/ready, 10 frames of a counting pattern.
        do_reset();
        sent = 0;
        cyc = 0;
        fe0 = a_fends;
        o0 = a_outs;
        while (sent < 10 * A_COLS * A_ROWS && cyc < 3000) begin
            in_valid  = 1'($urandom_range(1));
            in_data   = DW'(sent);
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        chk("rand_sent", sent, 10 * A_COLS * A_ROWS);
        drain_a();
        chk("rand_outputs", a_outs - o0, 10 * A_COLS * A_ROWS);
        chk("rand_frame_ends", a_fends - fe0, 10);

        // Two-column, one-row configuration under continuous traffic.
        b_out_ready = 1'b1;
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            b_in_valid = 1'b1;
            b_in_data = DW'($urandom);
            @(negedge clk);
            if (b_in_ready) sent++;
            tick();
        end
        b_in_valid = 1'b0;
        chk("b_no_stall", sent, 40);
        n = 0;
        while (b_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("b_outputs", b_outs, 40);
        chk("b_frame_ends", b_fends, 20);

        chk("a_queue_empty", a_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_line_mirror.md
# pixel_line_mirror

Streaming horizontal-reflection engine: it accepts a raster-order pixel stream (row 0 first, column 0 first within each row) and emits the same frame with every row reversed, out[r][c] = in[r][COLS-1-c]. It is the synthesizable, handshaked counterpart of the file-based reflection flow. It sits between the pixel source (file reader in simulation, sensor/DMA front end in hardware) and the downstream pixel sink. It uses two ping-pong line banks, so one row is captured while the previous row is drained in reverse.

## Interface
- COLS, 512, pixels per row (>= 2)
- ROWS, 512, rows per frame (>= 1)
- DATA_W, 8, bits per pixel
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  source presents a pixel
- in_ready  output  1  block can accept a pixel this cycle
- in_data  input  DATA_W  input pixel
- out_valid  output  1  out_data holds a valid mirrored pixel
- out_ready  input  1  sink accepts the pixel this cycle
- out_data  output  DATA_W  mirrored pixel
- out_last  output  1  qualifies the final pixel of a row (original column 0)
- out_frame_end  output  1  qualifies the final pixel of the frame (row ROWS-1, original column 0)

## Operation
- Storage: bank[0..1][0..COLS-1] of DATA_W bits; full[1:0] flags; wr_bank, wr_col; rd_bank, rd_col; rd_row (0..ROWS-1).
- Write side: accept when in_valid && in_ready. bank[wr_bank][wr_col] <= in_data; wr_col++. When wr_col == COLS-1 on accept: wr_col <= 0, full[wr_bank] <= 1, wr_bank toggles.
- in_ready = !full[wr_bank] (from registered state only; no combinational path from out_ready).
- Read side: out_valid = full[rd_bank]. out_data = bank[rd_bank][COLS-1-rd_col]. out_last = out_valid && rd_col == COLS-1. out_frame_end = out_last && rd_row == ROWS-1.
- Transfer when out_valid && out_ready: rd_col++. When rd_col == COLS-1: rd_col <= 0, full[rd_bank] <= 0, rd_bank toggles, rd_row <= (rd_row == ROWS-1) ? 0 : rd_row+1.
- Per-bank states: EMPTY (full=0, writer may fill) -> FULL (written last column) -> EMPTY (read last column). A bank is never written while FULL.
- Frames are back-to-back; no frame-start marker is required. Counters wrap at COLS-1 and ROWS-1.
- Simultaneous events: on a cycle where the reader drains the last pixel of bank X and the writer is blocked on bank X, full[X] clears at the edge, and in_ready rises the next cycle. Write-complete and read-complete on different banks in the same cycle both take effect.
- Holding: while out_valid && !out_ready, out_data, out_last and out_frame_end stay stable. in_data is ignored when !in_ready.
- Reset mid-row or mid-frame discards all buffered pixels. Bank contents need no clearing.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_frame_end=0, full=00, all counters 0, wr_bank=rd_bank=0. out_data is don't-care while out_valid=0.
- Latency: the first mirrored pixel of row r has out_valid=1 in the cycle after the edge that accepts input pixel (r, COLS-1).
- Throughput: with continuous in_valid and out_ready=1, the block sustains one pixel per cycle in steady state. The writer stalls only if the reader falls more than one row behind.
- Row r cannot appear on the output before all of its COLS pixels have been accepted.

## Test plan
- COLS=4, ROWS=2, reset, then stream 1,2,3,4,5,6,7,8 with out_ready=1 -> outputs 4,3,2,1 (out_last on 1), then 8,7,6,5 (out_last and out_frame_end on 5). First out_valid one cycle after 4 is accepted.
- Same parameters, out_ready=0 throughout, 12 pixels offered -> exactly 8 accepted, in_ready=0 afterward, out_valid=1 with out_data=4 held stable.
- Release out_ready after the stall above -> the drain of row 0 frees bank 0, in_ready returns the cycle after 1 is read, and pixels 9..12 enter. The output sequence continues 8,7,6,5,12,11,10,9.
- Random in_valid and out_ready (50% each), 3 frames of 512x512 with a counting pattern -> output equals the per-row reversal with no loss or duplication. out_frame_end appears every 262144 outputs.
- Assert rst after 2 pixels of row 1 with row 0 partly drained -> next cycle out_valid=0 and in_ready=1. A fresh frame 1..8 yields 4,3,2,1,8,7,6,5.
- COLS=2, ROWS=1, continuous traffic -> output pairs swapped every row, and out_last and out_frame_end assert on every second output.
